// File: rtl/mem_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arb                                                       |
// | Purpose  : Two-port arbiter in front of a single shared 32-bit memory.   |
// |            p0 is a read-only instruction-fetch port, p1 is a read/write  |
// |            data port. Each transaction takes one IDLE (grant) cycle and  |
// |            one ACCESS cycle. The response (rvalid/rdata/err) appears in  |
// |            the cycle after ACCESS, which may also grant the next request.|
// | Config   : MEM_ARB_RR_EN defined   -> round-robin between p0 and p1      |
// |            MEM_ARB_RR_EN undefined -> fixed priority, p1 always wins     |
// | Ports    : clk, reset_n          clock, asynchronous active-low reset    |
// |            p0_req/addr           fetch request                           |
// |            p0_gnt/rvalid/rdata/err  fetch grant and response             |
// |            p1_req/we/addr/wd     data request                            |
// |            p1_gnt/rvalid/rdata/err  data grant and response              |
// |            mem_we/a/wd, mem_rd   memory port (comb. read, clocked write) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arb #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  // fetch port
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  // data port
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  // memory port
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [29:0] c_mem_words = MEM_WORDS[29:0];

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_any_req;
  logic        w_pick_p1;    // winner if a grant is issued this cycle
  logic        w_grant;
  logic        w_done;       // last cycle of the current access
  logic [31:0] w_req_addr;
  logic        w_addr_err;

  // transaction latched at grant time; requester inputs are ignored afterwards
  logic        r_win_p1;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wd;

  assign w_any_req = p0_req | p1_req;

`ifdef MEM_ARB_RR_EN
  // Remembers which port won the most recent grant; on a tie the other port
  // wins. Reset value "p1" lets the fetch port go first out of reset.
  logic r_last_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_p1 <= 1'b1;
    end else if (w_grant) begin
      r_last_p1 <= w_pick_p1;
    end
  end

  assign w_pick_p1 = p1_req & (~p0_req | ~r_last_p1);
`else
  assign w_pick_p1 = p1_req;
`endif

  assign w_req_addr = w_pick_p1 ? p1_addr : p0_addr;
  // misaligned or beyond the end of the memory
  assign w_addr_err = (w_req_addr[1:0] != 2'b00) || (w_req_addr[31:2] >= c_mem_words);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          p1_gnt      = w_pick_p1;
          p0_gnt      = ~w_pick_p1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // a bad address never reaches the memory as a write
        mem_we      = r_we & ~r_err;
        mem_a       = r_addr;
        mem_wd      = r_wd;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_done = (r_state == ACCESS);

  // -------------------------------------------------------------------------
  // Transaction latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_p1 <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wd     <= '0;
    end else if (w_grant) begin
      r_win_p1 <= w_pick_p1;
      r_we     <= w_pick_p1 & p1_we;   // p0 can never write
      r_err    <= w_addr_err;
      r_addr   <= w_req_addr;
      r_wd     <= w_pick_p1 ? p1_wd : 32'h0;
    end
  end

  // -------------------------------------------------------------------------
  // Responses: one-cycle rvalid pulse after ACCESS; rdata holds between pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= w_done & ~r_win_p1;
      p0_err    <= w_done & ~r_win_p1 & r_err;
      p1_rvalid <= w_done & r_win_p1;
      p1_err    <= w_done & r_win_p1 & r_err;
      if (w_done && !r_win_p1) begin
        p0_rdata <= r_err ? 32'h0 : mem_rd;
      end
      if (w_done && r_win_p1) begin
        if (r_err) begin
          p1_rdata <= 32'h0;
        end else if (!r_we) begin
          p1_rdata <= mem_rd;
        end
        // a good write acknowledges without touching rdata
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arb                                                    |
// | Purpose  : Self-checking bench for mem_arb. A transaction-level model    |
// |            predicts grants, memory-port activity and responses every     |
// |            cycle; directed sequences add hand-computed literal checks.   |
// |            Build with or without MEM_ARB_RR_EN; expectations follow.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_arb;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0;
  logic [31:0] p0_addr = '0;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0;
  logic        p1_we = 1'b0;
  logic [31:0] p1_addr = '0;
  logic [31:0] p1_wd = '0;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wd     (p1_wd),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hE3A00005 : (32'hA500_0000 | 32'(i));
  endfunction

  // memory: combinational read, clocked write; loaded on the first clock
  logic [31:0] mem [MEM_WORDS];
  logic        mem_ready = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model + per-cycle compare
  // Rules: a grant may be issued only if none was issued the previous cycle;
  // the granted transaction uses the memory the next cycle and answers the
  // cycle after that.
  // -------------------------------------------------------------------------
  logic [31:0] ref_mem [MEM_WORDS];
  logic        last_p1;
  logic        acc_v, acc_p1, acc_we, acc_err;
  logic [31:0] acc_addr, acc_wd;
  logic        rsp_v, rsp_p1, rsp_err;
  logic [31:0] hold0, hold1;

  initial begin
    logic g0, g1;
    int   idx;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    last_p1 = 1'b1; acc_v = 0; rsp_v = 0; hold0 = 0; hold1 = 0;
    acc_p1 = 0; acc_we = 0; acc_err = 0; acc_addr = 0; acc_wd = 0;
    rsp_p1 = 0; rsp_err = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_err", p0_err, 0);
        chk("rst_p1_err", p1_err, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        last_p1 = 1'b1; acc_v = 0; rsp_v = 0; hold0 = 0; hold1 = 0;
      end else begin
        g0 = 0; g1 = 0;
        if (!acc_v && (p0_req || p1_req)) begin
          if (p0_req && p1_req) begin
`ifdef MEM_ARB_RR_EN
            g1 = !last_p1;
`else
            g1 = 1'b1;
`endif
          end else begin
            g1 = p1_req;
          end
          g0 = !g1;
        end
        chk("m_p0_gnt", p0_gnt, g0);
        chk("m_p1_gnt", p1_gnt, g1);
        chk("m_mem_we", mem_we, acc_v && acc_we && !acc_err);
        chk("m_mem_a", mem_a, acc_v ? acc_addr : 32'h0);
        chk("m_mem_wd", mem_wd, acc_v ? acc_wd : 32'h0);
        chk("m_p0_rvalid", p0_rvalid, rsp_v && !rsp_p1);
        chk("m_p1_rvalid", p1_rvalid, rsp_v && rsp_p1);
        chk("m_p0_err", p0_err, rsp_v && !rsp_p1 && rsp_err);
        chk("m_p1_err", p1_err, rsp_v && rsp_p1 && rsp_err);
        chk("m_p0_rdata", p0_rdata, hold0);
        chk("m_p1_rdata", p1_rdata, hold1);
        // the access in flight completes at the coming edge
        rsp_v = acc_v; rsp_p1 = acc_p1; rsp_err = acc_err;
        if (acc_v) begin
          idx = int'(acc_addr[31:2]);
          if (acc_err) begin
            if (acc_p1) hold1 = 0; else hold0 = 0;
          end else if (acc_we) begin
            ref_mem[idx] = acc_wd;
          end else if (acc_p1) begin
            hold1 = ref_mem[idx];
          end else begin
            hold0 = ref_mem[idx];
          end
        end
        // a grant now becomes the next access
        acc_v = g0 || g1;
        if (acc_v) begin
          acc_p1   = g1;
          acc_we   = g1 && p1_we;
          acc_addr = g1 ? p1_addr : p0_addr;
          acc_wd   = g1 ? p1_wd : 32'h0;
          acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= MEM_WORDS);
          last_p1  = g1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p1_bad_write(input logic [31:0] a);
    tick();
    p1_req = 1; p1_we = 1; p1_addr = a; p1_wd = 32'hCAFE_0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_mem_we", mem_we, 0);
      if (c == 2) begin
        chk("err_p1_rvalid", p1_rvalid, 1);
        chk("err_p1_err", p1_err, 1);
        chk("err_p1_rdata", p1_rdata, 0);
      end
      tick();
      p1_req = 0; p1_we = 0;
    end
  endtask

  logic gl[$];

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_p0_gnt", p0_gnt, 0);
    chk("reset_p1_rdata", p1_rdata, 0);
    tick();
    reset_n = 1;
    tick();

    // fetch of word 2
    p0_req = 1; p0_addr = 32'h8;
    @(negedge clk);
    chk("t1_p0_gnt", p0_gnt, 1);
    chk("t1_p1_gnt", p1_gnt, 0);
    tick(); p0_req = 0; p0_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    chk("t1_mem_a", mem_a, 32'h8);
    chk("t1_mem_we", mem_we, 0);
    tick();
    @(negedge clk);
    chk("t1_p0_rvalid", p0_rvalid, 1);
    chk("t1_p0_rdata", p0_rdata, 32'hE3A00005);
    chk("t1_p0_err", p0_err, 0);
    tick(); tick();

    // write then read back; inputs change right after grant
    p1_req = 1; p1_we = 1; p1_addr = 32'h10; p1_wd = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_p1_gnt", p1_gnt, 1);
    tick(); p1_req = 0; p1_we = 0; p1_addr = 32'h20; p1_wd = 0;
    @(negedge clk);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_a", mem_a, 32'h10);
    chk("t2_mem_wd", mem_wd, 32'hDEADBEEF);
    tick(); p1_req = 1; p1_we = 0; p1_addr = 32'h10;
    @(negedge clk);
    chk("t2_wack", p1_rvalid, 1);
    chk("t2_back2back_gnt", p1_gnt, 1);
    chk("t2_mem_we_once", mem_we, 0);
    tick(); p1_req = 0;
    @(negedge clk);
    chk("t2_mem_we_rd", mem_we, 0);
    tick();
    @(negedge clk);
    chk("t2_rd_rvalid", p1_rvalid, 1);
    chk("t2_rd_data", p1_rdata, 32'hDEADBEEF);
    tick(); tick();

    // both ports requesting for 8 cycles
    p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (p0_gnt) gl.push_back(1'b0);
      if (p1_gnt) gl.push_back(1'b1);
      tick();
    end
    p0_req = 0; p1_req = 0;
    chk("t3_gnt_count", gl.size(), 4);
    for (int i = 0; i < gl.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      chk("t3_gnt_order", gl[i], (i % 2) == 1);
`else
      chk("t3_gnt_order", gl[i], 1);
`endif
    end
    tick(); tick();

    // bad addresses
    p1_bad_write(32'h102);
    p1_bad_write(32'h100);
    chk("t4_mem0_intact", mem[0], init_word(0));
    tick();
    p0_req = 1; p0_addr = 32'h200;
    tick(); p0_req = 0;
    tick();
    @(negedge clk);
    chk("t4_p0_rvalid", p0_rvalid, 1);
    chk("t4_p0_err", p0_err, 1);
    chk("t4_p0_rdata", p0_rdata, 0);
    tick(); tick();

    // reset during the access of a write
    p1_req = 1; p1_we = 1; p1_addr = 32'h18; p1_wd = 32'h12345678;
    @(negedge clk);
    chk("t5_p1_gnt", p1_gnt, 1);
    tick(); p1_req = 0; p1_we = 0;
    chk("t5_mem_we_pre", mem_we, 1);
    reset_n = 0;
    #1;
    chk("t5_mem_we_drop", mem_we, 0);
    tick(); tick();
    reset_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_rvalid", p1_rvalid, 0);
      tick();
    end
    chk("t5_mem6_intact", mem[6], init_word(6));
    p1_req = 1; p1_addr = 32'h18;
    tick(); p1_req = 0;
    tick();
    @(negedge clk);
    chk("t5_rd_rvalid", p1_rvalid, 1);
    chk("t5_rd_data", p1_rdata, init_word(6));
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
